// File: rtl/cache_controller_if.sv
// Bundle of CPU, line-SRAM and main-memory signals for cache_controller.
// slave  : the controller's view (consumes CPU requests, drives SRAM and memory requests).
// master : the environment's view (CPU, line SRAM and main memory).
interface cache_controller_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 512,
  parameter int unsigned IDX_W  = 6
);
  // CPU load/store side
  logic [ADDR_W-1:0] phy_addr;
  logic [ADDR_W-1:0] data_from_cpu;
  logic              read_mem;
  logic              write_mem;
  logic [ADDR_W-1:0] data_to_cpu;
  logic              hit_miss;
  logic              ready_stall;
  // Way-agnostic line SRAM
  logic [IDX_W-1:0]  cache_mem_index;
  logic [LINE_W-1:0] cache_mem_data_in;
  logic              cache_mem_write_en;
  logic [LINE_W-1:0] cache_mem_data_out;
  // Main memory, single outstanding request
  logic [ADDR_W-1:0] main_mem_addr;
  logic [ADDR_W-1:0] main_mem_data_out;
  logic              main_mem_read_req;
  logic              main_mem_write_req;
  logic [LINE_W-1:0] main_mem_data_in;
  logic              main_mem_ready;

  modport slave (
    input  phy_addr, data_from_cpu, read_mem, write_mem,
    output data_to_cpu, hit_miss, ready_stall,
    output cache_mem_index, cache_mem_data_in, cache_mem_write_en,
    input  cache_mem_data_out,
    output main_mem_addr, main_mem_data_out, main_mem_read_req, main_mem_write_req,
    input  main_mem_data_in, main_mem_ready
  );

  modport master (
    output phy_addr, data_from_cpu, read_mem, write_mem,
    input  data_to_cpu, hit_miss, ready_stall,
    input  cache_mem_index, cache_mem_data_in, cache_mem_write_en,
    output cache_mem_data_out,
    input  main_mem_addr, main_mem_data_out, main_mem_read_req, main_mem_write_req,
    output main_mem_data_in, main_mem_ready
  );
endinterface

// File: rtl/cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate cache controller.
// Holds tags, valid bits and per-set LRU (next victim) internally; line data
// lives in an external SRAM that writes way lru[index] on cache_mem_write_en.
// Ports: clk, rst_n (async active-low), bus (cache_controller_if.slave):
//   CPU: phy_addr, data_from_cpu, read_mem, write_mem -> data_to_cpu, hit_miss, ready_stall
//   SRAM: cache_mem_index, cache_mem_data_in, cache_mem_write_en <- cache_mem_data_out
//   Memory: main_mem_addr, main_mem_data_out, main_mem_read_req, main_mem_write_req
//           <- main_mem_data_in, main_mem_ready
module cache_controller #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 512,
  parameter int unsigned SETS   = 64,
  parameter int unsigned TAG_W  = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  cache_controller_if.slave bus
);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
  localparam int unsigned BOFF_W = $clog2(ADDR_W / 8);
  localparam int unsigned WSEL_W = OFF_W - BOFF_W;
  localparam int unsigned BIT_W  = $clog2(ADDR_W);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, FILL, WR_REQ, WR_WAIT} state_e;

  state_e state_q, state_d;

  logic [TAG_W-1:0]       tag_q [2][SETS];
  logic [1:0][SETS-1:0]   valid_q;
  logic [SETS-1:0]        lru_q;

  logic [ADDR_W-1:0] addr_q, wdata_q, data_q, data_d;
  logic [LINE_W-1:0] line_q;
  logic              hit_q, hit_d, stall_q, stall_d;
  logic              rd_req_q, wr_req_q, sram_we_q;

  logic              accept, cap_we, tag_we;
  logic              lru_we, lru_val, vld_we, vld_way, vld_val;
  logic [IDX_W-1:0]  lru_idx, vld_idx;

  // Word select within a line
  function automatic logic [ADDR_W-1:0] pick_word(input logic [LINE_W-1:0] line,
                                                   input logic [WSEL_W-1:0] sel);
    return line[{sel, {BIT_W{1'b0}}} +: ADDR_W];
  endfunction

  // Address fields of the incoming request and of the latched one
  logic [IDX_W-1:0]  idx_in, idx_q;
  logic [TAG_W-1:0]  tag_in;
  logic [1:0]        way_hit;
  logic              hit, hit_way, victim;

  assign idx_in  = bus.phy_addr[OFF_W +: IDX_W];
  assign tag_in  = bus.phy_addr[ADDR_W-TAG_W +: TAG_W];
  assign idx_q   = addr_q[OFF_W +: IDX_W];
  assign way_hit[0] = valid_q[0][idx_in] && (tag_q[0][idx_in] == tag_in);
  assign way_hit[1] = valid_q[1][idx_in] && (tag_q[1][idx_in] == tag_in);
  assign hit     = |way_hit;
  assign hit_way = way_hit[1];
  assign victim  = lru_q[idx_q];

  // SRAM index follows the live address only while a new request can be accepted
  assign bus.cache_mem_index    = (state_q == IDLE) ? idx_in : idx_q;
  assign bus.cache_mem_data_in  = line_q;
  assign bus.cache_mem_write_en = sram_we_q;
  assign bus.main_mem_addr      = (state_q inside {WR_REQ, WR_WAIT}) ? addr_q
                                  : {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign bus.main_mem_data_out  = wdata_q;
  assign bus.main_mem_read_req  = rd_req_q;
  assign bus.main_mem_write_req = wr_req_q;
  assign bus.data_to_cpu        = data_q;
  assign bus.hit_miss           = hit_q;
  assign bus.ready_stall        = stall_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and control strobes
  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    hit_d   = hit_q;
    data_d  = data_q;
    accept  = 1'b0;
    cap_we  = 1'b0;
    tag_we  = 1'b0;
    lru_we  = 1'b0;
    lru_idx = idx_in;
    lru_val = 1'b0;
    vld_we  = 1'b0;
    vld_idx = idx_in;
    vld_way = hit_way;
    vld_val = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.write_mem) begin
          accept  = 1'b1;
          stall_d = 1'b1;
          hit_d   = hit;
          state_d = WR_REQ;
          // Write hit drops the line so no stale copy survives the write-through
          if (hit) begin
            vld_we  = 1'b1;
            lru_we  = 1'b1;
            lru_val = hit_way;
          end
        end else if (bus.read_mem) begin
          accept = 1'b1;
          if (hit) begin
            data_d  = pick_word(bus.cache_mem_data_out, bus.phy_addr[BOFF_W +: WSEL_W]);
            hit_d   = 1'b1;
            lru_we  = 1'b1;
            lru_val = ~hit_way;
          end else begin
            hit_d   = 1'b0;
            stall_d = 1'b1;
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: begin
        if (bus.main_mem_ready) begin
          cap_we  = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        tag_we  = 1'b1;
        vld_we  = 1'b1;
        vld_idx = idx_q;
        vld_way = victim;
        vld_val = 1'b1;
        lru_we  = 1'b1;
        lru_idx = idx_q;
        lru_val = ~victim;
        data_d  = pick_word(line_q, addr_q[BOFF_W +: WSEL_W]);
        stall_d = 1'b0;
        state_d = IDLE;
      end
      WR_REQ:  state_d = WR_WAIT;
      WR_WAIT: begin
        if (bus.main_mem_ready) begin
          stall_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered strobes; strobes decode the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      data_q    <= '0;
      line_q    <= '0;
      hit_q     <= 1'b0;
      stall_q   <= 1'b0;
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      sram_we_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= bus.phy_addr;
        wdata_q <= bus.data_from_cpu;
      end
      if (cap_we) line_q <= bus.main_mem_data_in;
      data_q    <= data_d;
      hit_q     <= hit_d;
      stall_q   <= stall_d;
      rd_req_q  <= (state_d == RD_REQ);
      wr_req_q  <= (state_d == WR_REQ);
      sram_we_q <= (state_d == FILL);
    end
  end

  // Valid and LRU state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      lru_q   <= '0;
    end else begin
      if (vld_we) valid_q[vld_way][vld_idx] <= vld_val;
      if (lru_we) lru_q[lru_idx] <= lru_val;
    end
  end

  // Tag array, only meaningful where valid is set
  always_ff @(posedge clk) begin
    if (tag_we) tag_q[victim][idx_q] <= addr_q[ADDR_W-TAG_W +: TAG_W];
  end
endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: directed accesses push expected CPU
// responses and memory requests; monitors compare when the DUT presents them.
module tb_cache_controller;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_controller_if bus();
  cache_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
  } mreq_t;

  typedef struct {
    logic        is_wr;
    logic        exp_hit;
    logic        exp_stall;
    logic [31:0] exp_data;
    int          exp_rd, exp_wr, exp_fill;
    int          rd_base, wr_base, fill_base;
  } rsp_t;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_cnt = 0, wr_cnt = 0, fill_cnt = 0;
  int issued_cnt = 0, done_cnt = 0;
  int spur_req = 0, spur_done = 0;
  logic [31:0] cur_addr = '0;
  rsp_t  sq[$];
  mreq_t mq[$];
  logic [511:0] sram   [bit [25:0]];
  logic [31:0]  mm_wr  [bit [29:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Main memory contents: word k of block b is b + (k << 24) unless written
  function automatic logic [511:0] mm_line(input logic [25:0] blk);
    logic [511:0] l;
    l = '0;
    for (int k = 0; k < 16; k++) begin
      logic [29:0] wa;
      logic [31:0] w;
      wa = {blk, 4'(k)};
      w  = 32'(blk) + (32'(k) << 24);
      if (mm_wr.exists(wa)) w = mm_wr[wa];
      l[k*32 +: 32] = w;
    end
    return l;
  endfunction

  // Line SRAM read port, keyed by set and tag so it is way-agnostic
  initial begin
    bus.cache_mem_data_out = '0;
    forever begin
      bit [25:0] k;
      @(negedge clk);
      #2;
      k = {bus.phy_addr[31:12], bus.cache_mem_index};
      bus.cache_mem_data_out = sram.exists(k) ? sram[k] : '0;
    end
  end

  // Main memory and SRAM write side
  initial begin
    logic         req_prev;
    int           delay;
    logic [511:0] rsp_line;
    mreq_t        m;
    req_prev = 1'b0;
    delay    = 0;
    rsp_line = '0;
    bus.main_mem_ready   = 1'b0;
    bus.main_mem_data_in = '0;
    forever begin
      @(negedge clk);
      bus.main_mem_ready = 1'b0;
      if (bus.cache_mem_write_en) begin
        fill_cnt++;
        check("fill_index", 64'(bus.cache_mem_index), 64'(cur_addr[11:6]));
        check("fill_line", 64'(bus.cache_mem_data_in == mm_line(cur_addr[31:6])), 64'(1));
        sram[cur_addr[31:6]] = bus.cache_mem_data_in;
      end
      if (bus.main_mem_read_req)  rd_cnt++;
      if (bus.main_mem_write_req) wr_cnt++;
      if ((bus.main_mem_read_req || bus.main_mem_write_req) && !req_prev) begin
        if (mq.size() == 0) begin
          check("unexpected_mem_req", 64'(1), 64'(0));
        end else begin
          m = mq.pop_front();
          check("mem_req_kind", 64'(bus.main_mem_write_req), 64'(m.is_wr));
          check("mem_req_addr", 64'(bus.main_mem_addr), 64'(m.addr));
          if (m.is_wr) begin
            check("mem_wr_data", 64'(bus.main_mem_data_out), 64'(m.data));
            mm_wr[m.addr[31:2]] = m.data;
          end
          rsp_line = mm_line(m.addr[31:6]);
          delay    = 3;
        end
      end
      req_prev = bus.main_mem_read_req || bus.main_mem_write_req;
      if (delay > 0) begin
        delay--;
        if (delay == 0) begin
          bus.main_mem_ready   = 1'b1;
          bus.main_mem_data_in = rsp_line;
        end
      end else if (spur_req != spur_done) begin
        bus.main_mem_ready = 1'b1;
        spur_done++;
      end
    end
  end

  // CPU response monitor
  initial begin
    int   looked;
    rsp_t e;
    looked = 0;
    forever begin
      @(negedge clk);
      if (issued_cnt != done_cnt && sq.size() > 0) begin
        e = sq[0];
        if (looked <= done_cnt) begin
          check("stall_after_accept", 64'(bus.ready_stall), 64'(e.exp_stall));
          looked = done_cnt + 1;
        end
        if (!bus.ready_stall) begin
          e = sq.pop_front();
          check(e.is_wr ? "wr_hit_miss" : "rd_hit_miss", 64'(bus.hit_miss), 64'(e.exp_hit));
          if (!e.is_wr) check("rd_data", 64'(bus.data_to_cpu), 64'(e.exp_data));
          check("rd_req_cycles", 64'(rd_cnt - e.rd_base), 64'(e.exp_rd));
          check("wr_req_cycles", 64'(wr_cnt - e.wr_base), 64'(e.exp_wr));
          check("sram_fills", 64'(fill_cnt - e.fill_base), 64'(e.exp_fill));
          done_cnt++;
        end
      end
    end
  end

  task automatic finish_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  // One CPU access with its hand-computed response
  task automatic access(input logic is_wr, input logic both, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic exp_hit, input logic [31:0] exp_data);
    rsp_t  e;
    mreq_t m;
    @(negedge clk);
    bus.phy_addr      = addr;
    bus.data_from_cpu = wdata;
    bus.write_mem     = is_wr;
    bus.read_mem      = !is_wr || both;
    cur_addr          = addr;
    e.is_wr     = is_wr;
    e.exp_hit   = exp_hit;
    e.exp_stall = is_wr || !exp_hit;
    e.exp_data  = exp_data;
    e.exp_rd    = (!is_wr && !exp_hit) ? 1 : 0;
    e.exp_wr    = is_wr ? 1 : 0;
    e.exp_fill  = e.exp_rd;
    e.rd_base   = rd_cnt;
    e.wr_base   = wr_cnt;
    e.fill_base = fill_cnt;
    sq.push_back(e);
    if (is_wr) begin
      m = '{1'b1, addr, wdata};
      mq.push_back(m);
    end else if (!exp_hit) begin
      m = '{1'b0, {addr[31:6], 6'b0}, 32'h0};
      mq.push_back(m);
    end
    @(posedge clk);
    #1;
    bus.read_mem  = 1'b0;
    bus.write_mem = 1'b0;
    issued_cnt++;
    for (int i = 0; i < 100 && issued_cnt != done_cnt; i++) @(negedge clk);
    if (issued_cnt != done_cnt) begin
      check("response_timeout", 64'(0), 64'(1));
      finish_test();
    end
  endtask

  initial begin
    int   base_rd, base_fill;
    mreq_t m;
    rst_n = 1'b0;
    bus.phy_addr      = '0;
    bus.data_from_cpu = '0;
    bus.read_mem      = 1'b0;
    bus.write_mem     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_to_cpu", 64'(bus.data_to_cpu), 64'(0));
    check("rst_hit_miss", 64'(bus.hit_miss), 64'(0));
    check("rst_ready_stall", 64'(bus.ready_stall), 64'(0));
    check("rst_read_req", 64'(bus.main_mem_read_req), 64'(0));
    check("rst_write_req", 64'(bus.main_mem_write_req), 64'(0));
    check("rst_sram_we", 64'(bus.cache_mem_write_en), 64'(0));
    check("rst_mem_addr", 64'(bus.main_mem_addr), 64'(0));
    check("rst_mem_wdata", 64'(bus.main_mem_data_out), 64'(0));
    rst_n = 1'b1;

    //     wr both addr          wdata         hit  data
    access(0, 0, 32'h0000_1000, 32'h0,        0, 32'h0000_0040);
    access(0, 0, 32'h0000_1000, 32'h0,        1, 32'h0000_0040);
    access(1, 0, 32'h0000_2000, 32'hCAFEBABE, 0, 32'h0);
    access(0, 0, 32'h0004_1004, 32'h0,        0, 32'h0100_1040);
    access(0, 0, 32'h0008_1000, 32'h0,        0, 32'h0000_2040);
    access(0, 0, 32'h0000_1000, 32'h0,        0, 32'h0000_0040);
    access(1, 0, 32'h0008_1000, 32'h12345678, 1, 32'h0);
    access(0, 0, 32'h0008_1000, 32'h0,        0, 32'h1234_5678);
    access(0, 0, 32'h0000_1000, 32'h0,        1, 32'h0000_0040);
    access(0, 0, 32'h0004_1000, 32'h0,        0, 32'h0000_1040);
    access(0, 0, 32'h0008_1000, 32'h0,        0, 32'h1234_5678);
    access(0, 0, 32'h0000_2000, 32'h0,        0, 32'hCAFE_BABE);
    access(1, 1, 32'h0000_3040, 32'h55,       0, 32'h0);
    access(0, 0, 32'h0000_3040, 32'h0,        0, 32'h0000_0055);
    spur_req++;
    repeat (3) @(negedge clk);
    access(0, 0, 32'h0000_3048, 32'h0,        1, 32'h0200_00C1);

    // Reset while a read miss waits on memory
    @(negedge clk);
    bus.phy_addr  = 32'h0000_5000;
    bus.read_mem  = 1'b1;
    cur_addr      = 32'h0000_5000;
    base_rd       = rd_cnt;
    m = '{1'b0, 32'h0000_5000, 32'h0};
    mq.push_back(m);
    @(posedge clk);
    #1;
    bus.read_mem = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("miss_req_before_reset", 64'(rd_cnt - base_rd), 64'(1));
    check("midrst_ready_stall", 64'(bus.ready_stall), 64'(0));
    check("midrst_read_req", 64'(bus.main_mem_read_req), 64'(0));
    check("midrst_sram_we", 64'(bus.cache_mem_write_en), 64'(0));
    check("midrst_mem_addr", 64'(bus.main_mem_addr), 64'(0));
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    base_rd   = rd_cnt;
    base_fill = fill_cnt;
    repeat (10) @(negedge clk);
    check("postrst_no_read_req", 64'(rd_cnt - base_rd), 64'(0));
    check("postrst_no_fill", 64'(fill_cnt - base_fill), 64'(0));
    check("postrst_ready_stall", 64'(bus.ready_stall), 64'(0));
    access(0, 0, 32'h0000_1000, 32'h0,        0, 32'h0000_0040);

    repeat (2) @(negedge clk);
    finish_test();
  end
endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Controller for a 2-way set-associative, write-through, no-write-allocate cache.
- Geometry: 64 sets, 64-byte (512-bit) lines, 32-bit physical addresses.
- Sits between the CPU load/store interface, an external way-agnostic line SRAM, and main memory with a single-outstanding request/ready handshake.
- Tags, valid bits and per-set LRU bits are held internally.

Parameters:
- ADDR_W, 32, physical address / CPU data width
- LINE_W, 512, cache line width in bits
- SETS, 64, number of sets (index = addr[11:6])
- TAG_W, 20, tag width (tag = addr[31:12]; word select = addr[5:2])

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- phy_addr  in  32  CPU physical address
- data_from_cpu  in  32  store data
- read_mem  in  1  load request, sampled in IDLE
- write_mem  in  1  store request, sampled in IDLE
- data_to_cpu  out  32  load data (registered)
- hit_miss  out  1  1 = last access hit, 0 = miss (registered)
- ready_stall  out  1  0 = ready/idle, 1 = busy (stall CPU)
- cache_mem_index  out  6  line SRAM set index
- cache_mem_data_in  out  512  line written to SRAM
- cache_mem_write_en  out  1  SRAM line write strobe
- cache_mem_data_out  in  512  SRAM line for the current index and requested tag, combinational
- main_mem_addr  out  32  main memory address
- main_mem_data_out  out  32  store word to main memory
- main_mem_read_req  out  1  line read request pulse
- main_mem_write_req  out  1  word write request pulse
- main_mem_data_in  in  512  line returned by main memory
- main_mem_ready  in  1  one-cycle completion pulse

Behaviour:
- Reset (async): all outputs 0, state IDLE, all valid bits 0, all lru_store bits 0, reg_phy_addr 0.
- SRAM contract: cache_mem_index = phy_addr[11:6] in IDLE, otherwise reg_phy_addr[11:6]. On cache_mem_write_en the SRAM wrapper writes way = lru_store[index] as seen before that edge.
- lru_store[set] always names the next victim way.
- States: IDLE, RD_REQ, RD_WAIT, FILL, WR_REQ, WR_WAIT.
- IDLE accept rules:
  - Requests are sampled only in IDLE. If write_mem and read_mem are both high, the write wins. Requests outside IDLE are ignored.
  - On accept, latch reg_phy_addr and the store data.
  - Tag compare over both ways uses phy_addr (valid && tag match).
- Read hit (1-cycle latency, no stall): at the accept edge, data_to_cpu <= cache_mem_data_out word addr[5:2], hit_miss <= 1, lru_store <= ~hit_way. ready_stall stays 0; state stays IDLE.
- Read miss:
  - Accept edge: hit_miss <= 0, ready_stall <= 1, go to RD_REQ.
  - RD_REQ: main_mem_read_req = 1 for exactly one cycle; main_mem_addr = {reg_phy_addr[31:6], 6'b0}; go to RD_WAIT.
  - RD_WAIT: hold main_mem_addr; on main_mem_ready, capture main_mem_data_in and go to FILL.
  - FILL (one cycle): cache_mem_write_en = 1 and cache_mem_data_in = captured line. For victim v = lru_store[idx]: tag[idx][v] <= tag, valid <= 1, lru_store <= ~v. data_to_cpu <= word addr[5:2] of the line; ready_stall <= 0; go to IDLE.
- Write (always stalls):
  - Accept edge: ready_stall <= 1, hit_miss <= hit.
  - On a hit in way w: valid[idx][w] <= 0 and lru_store <= w (write-hit invalidate, so no stale data).
  - A miss is not allocated and leaves lru unchanged.
  - WR_REQ: main_mem_write_req = 1 for one cycle; main_mem_addr = reg_phy_addr; main_mem_data_out = latched data (held until done).
  - WR_WAIT: on main_mem_ready, ready_stall <= 0 and go to IDLE.
- main_mem_ready outside a wait state is ignored. No timeout; the controller waits indefinitely.
- Reset mid-operation aborts immediately with no memory request or SRAM write issued afterwards.

Test Plan:
- Reset, then read 0x00001000 (mem block 64 holds value 64): ready_stall rises, one read req for block 64, FILL writes index 0 way 0 with tag 0x00001, ready_stall returns to 0, data_to_cpu = 64, hit_miss = 0.
- Re-read 0x00001000: at the accept edge, hit_miss = 1, ready_stall = 0, data_to_cpu = 0x40; no main memory request.
- Write 0xCAFEBABE to 0x00002000: stall, one write req with addr 0x2000 and data 0xCAFEBABE, no cache write, ready returns; main memory block 128 word 0 = 0xCAFEBABE.
- Read 0x00041000 then 0x00081000: the first fills index 0 way 1, the second evicts way 0 (tag 0x00001) and fills it with tag 0x00081; both report hit_miss = 0.
- Read 0x00001000 again: hit_miss = 0 after the accept edge and a full miss refill follows.
- Write hit to 0x00081000, then read it: the write invalidates the way, and the read misses and refetches the updated block.
